// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with hold and scan modes.
// Scan mode walks the hot bit through every position, dwelling DWELL cycles on each.
module decoder_nto2n_seq #(
  parameter int unsigned SEL_W = 2,
  parameter int unsigned OUT_W = 2**SEL_W,
  parameter int unsigned DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] y,
  output logic [SEL_W-1:0] idx,
  output logic             valid,
  output logic             wrap
);

  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             load_ok;

  assign load_ok = en & load;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next state: disable wins over load, load picks the mode
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = ST_IDLE;
    end else if (load) begin
      state_d = mode ? ST_SCAN : ST_HOLD;
    end
  end

  // Datapath and registered output values; a load overrides any scan advance
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load_ok) begin
      idx_d = sel;
      cnt_d = '0;
    end else if (en && (state_q == ST_SCAN)) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        idx_d  = idx_q + SEL_W'(1);
        wrap_d = (idx_q == IDX_LAST);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    valid_d = (state_d != ST_IDLE);
    y_d     = valid_d ? (OUT_W'(1) << idx_d) : '0;
  end

  assign y     = y_q;
  assign idx   = idx_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Self-checking bench for decoder_nto2n_seq: two instances (SEL_W=2/DWELL=3 and
// SEL_W=3/DWELL=1) share stimulus and are compared against a time-based model.
module tb_decoder_nto2n_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       load;
  logic       mode;
  logic [2:0] sel3;
  logic [1:0] sel2;

  logic [3:0] y0;
  logic [1:0] idx0;
  logic       v0, w0;
  logic [7:0] y1;
  logic [2:0] idx1;
  logic       v1, w1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  assign sel2 = sel3[1:0];

  decoder_nto2n_seq #(.SEL_W(2), .DWELL(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .mode(mode), .sel(sel2),
    .y(y0), .idx(idx0), .valid(v0), .wrap(w0)
  );

  decoder_nto2n_seq #(.SEL_W(3), .DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .mode(mode), .sel(sel3),
    .y(y1), .idx(idx1), .valid(v1), .wrap(w1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 0 = idle, 1 = hold, 2 = scan. Scan position is derived
  // from elapsed cycles since the load rather than from a dwell counter.
  int m_state [2];
  int m_idx   [2];
  int m_start [2];
  int m_t     [2];
  int m_wrap  [2];
  int m_outw  [2] = '{4, 8};
  int m_dwell [2] = '{3, 1};

  function automatic int exp_idx(input int k);
    if (m_state[k] == 2) return (m_start[k] + m_t[k] / m_dwell[k]) % m_outw[k];
    return m_idx[k];
  endfunction

  function automatic int exp_y(input int k);
    if (m_state[k] == 0) return 0;
    return 1 << exp_idx(k);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_idx[k] = 0; m_start[k] = 0; m_t[k] = 0; m_wrap[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int s;
      s = int'(sel3) % m_outw[k];
      if (!en) begin
        m_idx[k]   = exp_idx(k);
        m_state[k] = 0;
        m_wrap[k]  = 0;
      end else if (load) begin
        m_state[k] = mode ? 2 : 1;
        m_idx[k]   = s;
        m_start[k] = s;
        m_t[k]     = 0;
        m_wrap[k]  = 0;
      end else if (m_state[k] == 2) begin
        m_t[k]    = m_t[k] + 1;
        m_wrap[k] = ((m_t[k] % m_dwell[k]) == 0 && exp_idx(k) == 0) ? 1 : 0;
      end else begin
        m_wrap[k] = 0;
      end
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic compare_all();
    check_eq("y0",     32'(y0),   32'(exp_y(0)));
    check_eq("idx0",   32'(idx0), 32'(exp_idx(0)));
    check_eq("valid0", 32'(v0),   32'(m_state[0] != 0));
    check_eq("wrap0",  32'(w0),   32'(m_wrap[0]));
    check_eq("onehot0", 32'($countones(y0)), 32'(m_state[0] != 0));
    check_eq("y1",     32'(y1),   32'(exp_y(1)));
    check_eq("idx1",   32'(idx1), 32'(exp_idx(1)));
    check_eq("valid1", 32'(v1),   32'(m_state[1] != 0));
    check_eq("wrap1",  32'(w1),   32'(m_wrap[1]));
    check_eq("onehot1", 32'($countones(y1)), 32'(m_state[1] != 0));
  endtask

  // One clock: model follows the edge, outputs sampled 1 unit later
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic drive(input logic e, input logic l, input logic m, input logic [2:0] s);
    en = e; load = l; mode = m; sel3 = s;
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check_eq("rst_y0_now", 32'(y0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int last_wrap;
    int nwrap;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0);
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Reset then hold: load sel=2, then change sel without load
    drive(1'b1, 1'b1, 1'b0, 3'd2);
    cycle();
    check_eq("hold_y0", 32'(y0), 32'h4);
    drive(1'b1, 1'b0, 1'b0, 3'd3);
    for (int i = 0; i < 3; i++) cycle();
    check_eq("hold_keep_y0", 32'(y0), 32'h4);

    // Exhaustive hold decode
    for (int s = 0; s < 8; s++) begin
      drive(1'b1, 1'b1, 1'b0, 3'(s));
      cycle();
      check_eq("dec_y1", 32'(y1), 32'(1) << s);
    end

    // Scan from sel=2 with wrap period measured on the DWELL=3 instance
    drive(1'b1, 1'b1, 1'b1, 3'd2);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 3'd5);
    last_wrap = -1;
    nwrap = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (w0) begin
        if (last_wrap >= 0) check_eq("wrap_period", 32'(cyc - last_wrap), 32'd12);
        last_wrap = cyc;
        nwrap++;
      end
    end
    check_eq("wrap_count", 32'(nwrap >= 2), 32'd1);

    // DWELL=1 scan from 0 with a mid-scan reload to 1
    drive(1'b1, 1'b1, 1'b1, 3'd0);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    cycle();
    cycle();
    check_eq("scan1_idx", 32'(idx1), 32'd2);
    drive(1'b1, 1'b1, 1'b1, 3'd1);
    cycle();
    check_eq("reload_idx1", 32'(idx1), 32'd1);
    check_eq("reload_wrap1", 32'(w1), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 5; i++) cycle();

    // en=0 with load=1 drops the load; en=1 without load stays idle
    drive(1'b0, 1'b1, 1'b0, 3'd6);
    cycle();
    check_eq("dis_valid1", 32'(v1), 32'd0);
    check_eq("dis_y0", 32'(y0), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 3'd3);
    for (int i = 0; i < 3; i++) cycle();
    check_eq("idle_stay1", 32'(v1), 32'd0);

    // Asynchronous reset mid-scan
    drive(1'b1, 1'b1, 1'b1, 3'd3);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    async_reset();
    for (int i = 0; i < 3; i++) cycle();
    check_eq("post_rst_idle0", 32'(v0), 32'd0);

    // Randomised traffic with occasional mid-cycle resets
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 15) != 0), ($urandom_range(0, 9) < 2),
            1'($urandom), 3'($urandom));
      cycle();
      if ($urandom_range(0, 99) == 0) async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_nto2n_seq.md
# decoder_nto2n_seq

Registered, parametrised N-to-2^N one-hot decoder and the successor to the fixed 2-to-4 decoders in the primary-circuits library. It has two modes. In hold mode it latches a select value and drives the matching one-hot output. In scan mode it walks the one-hot output through every position, spending a programmable dwell time on each, which suits row/digit scanning. All outputs are registered. A small state machine and a dwell counter provide the sequencing.

## Interface
- SEL_W, default 2: select width N. Legal range 1..8.
- OUT_W, default 2**SEL_W: output width. Derived; never overridden.
- DWELL, default 4: clock cycles spent on each position in scan mode. Must be ≥ 1.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  block enable. Low forces IDLE on the next edge.
- load  in  1  capture request. Sampled only when en=1.
- mode  in  1  0 = hold/decode, 1 = scan. Sampled only on an accepted load.
- sel  in  SEL_W  select value (hold) or scan start index (scan). Sampled on an accepted load.
- y  out  OUT_W  one-hot output. y[idx]=1 when valid=1; all zeros otherwise.
- idx  out  SEL_W  currently decoded index.
- valid  out  1  high in HOLD and SCAN.
- wrap  out  1  one-cycle pulse when the scan index rolls over from OUT_W-1 to 0.

## Operation
- States: IDLE, HOLD, SCAN. An accepted load is load=1 with en=1.
- IDLE:
  - y=0, valid=0, wrap=0.
  - On an accepted load: idx←sel, cnt←0. Next state is HOLD if mode=0, SCAN if mode=1.
- HOLD:
  - y=1<<idx, unchanged until the next event.
  - Accepted load: recapture sel and mode. Transition to SCAN is allowed.
  - en=0: go to IDLE.
- SCAN:
  - cnt counts 0..DWELL-1.
  - When cnt=DWELL-1: cnt←0 and idx←(idx+1) mod OUT_W.
  - When idx=OUT_W-1 advances to 0, wrap=1 for exactly that cycle, coincident with idx=0.
  - Accepted load: restart at the new sel with cnt←0 and no wrap. Load has priority over the advance in the same cycle.
  - en=0: go to IDLE.
- Signal rules:
  - en=0 overrides load.
  - mode and sel changes without an accepted load are ignored.
  - Out-of-range values cannot occur; idx is exactly SEL_W bits and the increment wraps naturally.
- Encoding: bit i of y corresponds to index i. LSB = index 0.
- Invariant: the state machine never produces more than one hot bit. With valid=0, y is zero.

## Timing
- Reset (asynchronous, immediate):
  - y=0, idx=0, valid=0, wrap=0, cnt=0, state IDLE.
  - Release is synchronous to clk. The first load is accepted on the first rising edge with rst_n=1.
- Reset during SCAN or HOLD clears everything immediately. No partial outputs.
- Load latency: y/idx/valid update on the edge that samples the load, so they are visible 1 cycle after load is asserted.
- Scan step: each index holds y for exactly DWELL cycles. With DWELL=1, idx advances every cycle.
- First dwell after a load into SCAN is a full DWELL cycles at sel.
- Full period: OUT_W×DWELL cycles between consecutive wrap pulses.
- en deasserted: y=0 and valid=0 one cycle later. cnt and idx hold their last value. Re-entry requires a new accepted load.
- Simultaneous en=0 and load=1: go to IDLE; the load is dropped.

## Test plan
- Reset then hold: SEL_W=2. load=1, mode=0, sel=2 for one cycle → next cycle y=4'b0100, idx=2, valid=1. Then drive sel=3 with no load → y stays 4'b0100.
- Exhaustive hold decode: SEL_W=3. Load each sel 0..7 → y=1<<sel each time, exactly one bit set, wrap=0 throughout.
- Scan sequence: SEL_W=2, DWELL=3, load sel=2, mode=1 → y=0100 for 3 cycles, then 1000 ×3, then 0001 ×3 with wrap=1 on the first of those cycles, then 0010 ×3. Next wrap follows 12 cycles after the first.
- DWELL=1 with a mid-scan reload: SEL_W=2, scan from 0 → idx 0,1,2,3,0 on consecutive cycles. Load sel=1 on the cycle that would advance 2→3 → next idx=1, wrap never asserts.
- Enable and priority: assert en=0 together with load=1 during SCAN → next cycle y=0, valid=0, and the load is ignored. Assert en=1 with no load → stays IDLE.
- Asynchronous reset mid-scan: pulse rst_n=0 between clock edges while idx=3 → y=0, idx=0, valid=0 immediately. After release, stays IDLE until the next load.
